// File: rtl/sys_ram_ctrl.sv
// sys_ram_ctrl: byte-addressed, byte-enabled system-memory model with
// configurable read latency and range/alignment checking.
//
// Ports
//   CLK       system clock, rising edge
//   RESET     synchronous reset, active-high
//   address   byte address of request (ADDR_W)
//   data_in   write data (DATA_W)
//   byte_en   write lane enables, bit i -> data_in[8i+7:8i]
//   write     write request
//   read      read request
//   data_out  read data, valid on ack && !err of a read; holds otherwise
//   ack       one-cycle completion pulse per accepted request
//   err       qualifies ack: request rejected
//   busy      read outstanding; requests sampled while high are dropped
module sys_ram_ctrl #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       RD_LAT    = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic                write,
  input  logic                read,
  output logic [DATA_W-1:0]   data_out,
  output logic                ack,
  output logic                err,
  output logic                busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned LSB   = $clog2(BE_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RD_WAIT = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_word_q, rd_word_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  // Address decode, all at full ADDR_W so high bits can never alias.
  logic [ADDR_W-1:0] off_c, idx_c;
  logic              below_c, oob_c, misalign_c, bad_c, accept_c, wr_en_c;
  logic [DATA_W-1:0] word_c;

  assign off_c      = address - BASE_ADDR;
  assign idx_c      = off_c >> LSB;
  assign below_c    = address < BASE_ADDR;
  assign oob_c      = idx_c >= ADDR_W'(DEPTH);
  assign misalign_c = off_c[LSB-1:0] != '0;
  assign bad_c      = below_c | oob_c | misalign_c | (read & write);
  assign accept_c   = (read | write) & (state_q == S_IDLE);
  assign wr_en_c    = accept_c & write & ~bad_c;
  // Read data is the pre-write word; only meaningful when the request is good.
  assign word_c     = mem_q[idx_c[IDX_W-1:0]];

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_word_d  = rd_word_q;
    data_out_d = data_out_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bad_c) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (write) begin
            ack_d = 1'b1;
          end else if (RD_LAT == 1) begin
            ack_d      = 1'b1;
            data_out_d = word_c;
          end else begin
            state_d   = S_RD_WAIT;
            cnt_d     = CNT_W'(RD_LAT - 1);
            rd_word_d = word_c;
          end
        end
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter reaching zero on this edge completes the read.
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_IDLE;
          ack_d      = 1'b1;
          data_out_d = rd_word_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_word_q  <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_word_q  <= rd_word_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // Storage array: never cleared, so contents survive RESET.
  always_ff @(posedge CLK) begin
    if (!RESET && wr_en_c) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byte_en[i]) mem_q[idx_c[IDX_W-1:0]][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  assign data_out = data_out_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = (state_q == S_RD_WAIT);

endmodule
